// File: rtl/data_mem_responder.sv
// Data-memory responder: multi-cycle load/store engine behind the decoder's MEM stage.
// Stalls the pipeline with busy, handles lane select, extension and misalignment rejects.
module data_mem_responder #(
  parameter int ADDR_BITS      = 10,
  parameter int ACCESS_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_en,
  input  logic        mem_write_en,
  input  logic [2:0]  func3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        busy,
  output logic        error
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ACCESS_LATENCY - 1);

  state_t                 state_reg, state_next;
  logic [3:0]             cnt_reg, cnt_next;
  logic [ADDR_BITS+1:0]   addr_reg;
  logic [31:0]            wdata_reg;
  logic [2:0]             func3_reg;
  logic                   rd_reg, wr_reg;
  logic [31:0]            read_data_reg;
  logic                   error_reg;
  logic                   capture, finish, start;

  logic [31:0]            ram [0:2**ADDR_BITS-1];
  logic [31:0]            ram_q;
  logic [ADDR_BITS-1:0]   rd_idx, wr_idx;
  logic                   ram_we;

  logic                   reject;
  logic [7:0]             byte_sel;
  logic [15:0]            half_sel;
  logic [31:0]            load_value;
  logic [3:0]             byte_en;
  logic [31:0]            wr_lanes, merged_word;

  // Bits above the RAM index only wrap the address space.
  logic                   unused_addr_bits;
  assign unused_addr_bits = ^address[31:ADDR_BITS+2];

  assign start = mem_read_en | mem_write_en;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    capture    = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          capture    = 1'b1;
          cnt_next   = LAT_M1;
          state_next = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_reg == 4'd0) begin
          finish     = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg - 4'd1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    reject = 1'b0;
    if (rd_reg && wr_reg)                                   reject = 1'b1;
    if (func3_reg == 3'b011 || func3_reg[2:1] == 2'b11)     reject = 1'b1;
    if (wr_reg && func3_reg[2])                             reject = 1'b1;
    if (func3_reg[1:0] == 2'b01 && addr_reg[0])             reject = 1'b1;
    if (func3_reg == 3'b010 && addr_reg[1:0] != 2'b00)      reject = 1'b1;
  end

  always_comb begin
    byte_sel = ram_q[7:0];
    case (addr_reg[1:0])
      2'd1:    byte_sel = ram_q[15:8];
      2'd2:    byte_sel = ram_q[23:16];
      2'd3:    byte_sel = ram_q[31:24];
      default: byte_sel = ram_q[7:0];
    endcase
    half_sel = addr_reg[1] ? ram_q[31:16] : ram_q[15:0];
    case (func3_reg)
      3'b000:  load_value = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_value = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_value = {24'd0, byte_sel};
      3'b101:  load_value = {16'd0, half_sel};
      default: load_value = ram_q;
    endcase
  end

  always_comb begin
    case (func3_reg[1:0])
      2'b00: begin
        byte_en  = 4'b0001 << addr_reg[1:0];
        wr_lanes = {4{wdata_reg[7:0]}};
      end
      2'b01: begin
        byte_en  = addr_reg[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{wdata_reg[15:0]}};
      end
      default: begin
        byte_en  = 4'b1111;
        wr_lanes = wdata_reg;
      end
    endcase
  end

  // Read-modify-write: ram_q already holds the target word during ACCESS.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign merged_word[8*gi +: 8] = byte_en[gi] ? wr_lanes[8*gi +: 8] : ram_q[8*gi +: 8];
    end
  endgenerate

  assign rd_idx = (state_reg == IDLE) ? address[ADDR_BITS+1:2] : addr_reg[ADDR_BITS+1:2];
  assign wr_idx = addr_reg[ADDR_BITS+1:2];
  assign ram_we = rst_n & finish & wr_reg & ~reject;

  always_ff @(posedge clk) begin
    if (ram_we) ram[wr_idx] <= merged_word;
    ram_q <= ram[rd_idx];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= 4'd0;
      addr_reg      <= '0;
      wdata_reg     <= 32'd0;
      func3_reg     <= 3'd0;
      rd_reg        <= 1'b0;
      wr_reg        <= 1'b0;
      read_data_reg <= 32'd0;
      error_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (capture) begin
        addr_reg  <= address[ADDR_BITS+1:0];
        wdata_reg <= write_data;
        func3_reg <= func3;
        rd_reg    <= mem_read_en;
        wr_reg    <= mem_write_en;
      end
      if (finish) begin
        error_reg <= reject;
        if (reject)      read_data_reg <= 32'd0;
        else if (rd_reg) read_data_reg <= load_value;
      end else if (state_reg == DONE) begin
        error_reg <= 1'b0;
      end
    end
  end

  assign read_data = read_data_reg;
  assign error     = error_reg;
  assign busy      = rst_n & ((state_reg == ACCESS) | ((state_reg == IDLE) & start));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus randomized traffic against a
// byte-level memory model; a second instance covers single-cycle latency.
module tb_data_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        re0, we0, re1, we1;
  logic [2:0]  f30, f31;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [31:0] rdata0, rdata1;
  logic        busy0, busy1, err0, err1;

  int errors = 0;
  int checks = 0;

  data_mem_responder #(.ADDR_BITS(10), .ACCESS_LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .mem_read_en(re0), .mem_write_en(we0), .func3(f30),
    .address(addr0), .write_data(wd0), .read_data(rdata0), .busy(busy0), .error(err0));

  data_mem_responder #(.ADDR_BITS(10), .ACCESS_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_read_en(re1), .mem_write_en(we1), .func3(f31),
    .address(addr1), .write_data(wd1), .read_data(rdata1), .busy(busy1), .error(err1));

  // Starts at a falling edge: presents the request, counts busy cycles, samples the DONE
  // cycle, releases the enables and returns one cycle later (back in IDLE).
  task automatic do_access(input bit sel, input bit rd, input bit wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd, output int bc,
                           output logic [31:0] rdv, output logic erv, output logic err_after);
    if (!sel) begin re0 = rd; we0 = wr; f30 = f3; addr0 = a; wd0 = wd; end
    else      begin re1 = rd; we1 = wr; f31 = f3; addr1 = a; wd1 = wd; end
    bc = 0;
    #1;
    while ((sel ? busy1 : busy0) === 1'b1 && bc < 40) begin
      bc++;
      @(negedge clk); #1;
    end
    rdv = sel ? rdata1 : rdata0;
    erv = sel ? err1 : err0;
    re0 = 0; we0 = 0; re1 = 0; we1 = 0;
    @(negedge clk);
    err_after = sel ? err1 : err0;
    $display("op sel=%0d rd=%0d wr=%0d f3=%03b addr=%08h wd=%08h busy_cycles=%0d rdata=%08h err=%0b",
             sel, rd, wr, f3, a, wd, bc, rdv, erv);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %08h want 0", rdata0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err0); end
    checks++; if (rdata1 !== 32'd0) begin errors++; $display("FAIL reset_rdata1: got %08h want 0", rdata1); end
    re0 = 1; #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy_forced: got %b want 0", busy0); end
    re0 = 0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_word_round_trip();
    int bc; logic [31:0] r; logic e, ea;
    do_access(0, 0, 1, 3'b010, 32'h100, 32'h12345678, bc, r, e, ea);
    checks++; if (bc !== 3) begin errors++; $display("FAIL sw_busy: got %0d want 3", bc); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL sw_err: got %b want 0", e); end
    do_access(0, 1, 0, 3'b010, 32'h100, 32'h0, bc, r, e, ea);
    checks++; if (bc !== 3) begin errors++; $display("FAIL lw_busy: got %0d want 3", bc); end
    checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL lw_data: got %08h want 12345678", r); end
  endtask

  task automatic test_extension();
    int bc; logic [31:0] r; logic e, ea;
    logic [2:0]  f3s [5] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b001};
    logic [31:0] ads [5] = '{32'h23, 32'h23, 32'h20, 32'h22, 32'h22};
    logic [31:0] exs [5] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F01, 32'h000080FF, 32'hFFFF80FF};
    do_access(0, 0, 1, 3'b010, 32'h20, 32'h80FF7F01, bc, r, e, ea);
    for (int i = 0; i < 5; i++) begin
      do_access(0, 1, 0, f3s[i], ads[i], 32'h0, bc, r, e, ea);
      checks++;
      if (r !== exs[i]) begin errors++; $display("FAIL ext_%0d: got %08h want %08h", i, r, exs[i]); end
    end
  endtask

  task automatic test_partial_store();
    int bc; logic [31:0] r; logic e, ea;
    do_access(0, 0, 1, 3'b010, 32'h30, 32'h0, bc, r, e, ea);
    checks++; if (r !== 32'hFFFF80FF) begin errors++; $display("FAIL store_keeps_rdata: got %08h want ffff80ff", r); end
    do_access(0, 0, 1, 3'b000, 32'h31, 32'h123456AA, bc, r, e, ea);
    do_access(0, 0, 1, 3'b001, 32'h32, 32'hFFFFBBCC, bc, r, e, ea);
    do_access(0, 1, 0, 3'b010, 32'h30, 32'h0, bc, r, e, ea);
    checks++; if (r !== 32'hBBCCAA00) begin errors++; $display("FAIL partial_lw: got %08h want bbccaa00", r); end
  endtask

  task automatic test_rejections();
    int bc; logic [31:0] r; logic e, ea;
    do_access(0, 0, 1, 3'b010, 32'h100, 32'hCAFEF00D, bc, r, e, ea);
    do_access(0, 0, 1, 3'b010, 32'h104, 32'h0BADC0DE, bc, r, e, ea);
    do_access(0, 1, 0, 3'b010, 32'h102, 32'h0, bc, r, e, ea);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rej_lw_err: got %b want 1", e); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rej_lw_rdata: got %08h want 0", r); end
    checks++; if (bc !== 3) begin errors++; $display("FAIL rej_lw_busy: got %0d want 3", bc); end
    checks++; if (ea !== 1'b0) begin errors++; $display("FAIL rej_err_clear: got %b want 0", ea); end
    do_access(0, 0, 1, 3'b001, 32'h105, 32'hFFFF, bc, r, e, ea);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rej_sh_err: got %b want 1", e); end
    do_access(0, 1, 0, 3'b011, 32'h100, 32'h0, bc, r, e, ea);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rej_f3_err: got %b want 1", e); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rej_f3_rdata: got %08h want 0", r); end
    do_access(0, 1, 1, 3'b010, 32'h104, 32'hFFFFFFFF, bc, r, e, ea);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL rej_both_err: got %b want 1", e); end
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL rej_both_rdata: got %08h want 0", r); end
    do_access(0, 1, 0, 3'b010, 32'h100, 32'h0, bc, r, e, ea);
    checks++; if (r !== 32'hCAFEF00D) begin errors++; $display("FAIL rej_keep_100: got %08h want cafef00d", r); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL legal_err: got %b want 0", e); end
    do_access(0, 1, 0, 3'b010, 32'h104, 32'h0, bc, r, e, ea);
    checks++; if (r !== 32'h0BADC0DE) begin errors++; $display("FAIL rej_keep_104: got %08h want 0badc0de", r); end
  endtask

  task automatic test_wrap_latency();
    int bc; logic [31:0] r; logic e, ea;
    do_access(0, 0, 1, 3'b010, 32'h1000, 32'h5A5A5A5A, bc, r, e, ea);
    do_access(0, 1, 0, 3'b010, 32'h0, 32'h0, bc, r, e, ea);
    checks++; if (r !== 32'h5A5A5A5A) begin errors++; $display("FAIL wrap_lw: got %08h want 5a5a5a5a", r); end
    do_access(1, 0, 1, 3'b010, 32'h8, 32'h13579BDF, bc, r, e, ea);
    checks++; if (bc !== 2) begin errors++; $display("FAIL lat1_sw_busy: got %0d want 2", bc); end
    do_access(1, 1, 0, 3'b010, 32'h8, 32'h0, bc, r, e, ea);
    checks++; if (bc !== 2) begin errors++; $display("FAIL lat1_lw_busy: got %0d want 2", bc); end
    checks++; if (r !== 32'h13579BDF) begin errors++; $display("FAIL lat1_lw_data: got %08h want 13579bdf", r); end
  endtask

  task automatic test_reset_mid_access();
    int bc; logic [31:0] r; logic e, ea;
    do_access(0, 0, 1, 3'b010, 32'h40, 32'h11111111, bc, r, e, ea);
    do_access(0, 1, 0, 3'b010, 32'h40, 32'h0, bc, r, e, ea);
    checks++; if (r !== 32'h11111111) begin errors++; $display("FAIL pre_reset_lw: got %08h want 11111111", r); end
    we0 = 1; f30 = 3'b010; addr0 = 32'h40; wd0 = 32'hDEADBEEF;
    @(posedge clk); #2;
    rst_n = 1'b0; we0 = 0;
    #1;
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", busy0); end
    checks++; if (rdata0 !== 32'd0) begin errors++; $display("FAIL midrst_rdata: got %08h want 0", rdata0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL midrst_err: got %b want 0", err0); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_access(0, 1, 0, 3'b010, 32'h40, 32'h0, bc, r, e, ea);
    checks++; if (r !== 32'h11111111) begin errors++; $display("FAIL post_reset_lw: got %08h want 11111111", r); end
  endtask

  // Model: eight words at byte 0x200, each access judged by size/alignment arithmetic.
  task automatic test_random_back_to_back();
    int bc; logic [31:0] r; logic e, ea;
    logic [31:0] mem_m [8];
    logic [31:0] exp_rd;
    bit known = 0;
    for (int i = 0; i < 8; i++) begin
      mem_m[i] = $urandom;
      do_access(0, 0, 1, 3'b010, 32'h200 + 32'(4 * i), mem_m[i], bc, r, e, ea);
    end
    for (int n = 0; n < 60; n++) begin
      int kind = $urandom_range(0, 9);
      bit rd = (kind == 0) || (kind >= 5);
      bit wr = (kind <= 4);
      logic [2:0] f3 = 3'($urandom_range(0, 7));
      int off = $urandom_range(0, 31);
      int lane = off % 4;
      int size = 1 << f3[1:0];
      logic [31:0] a = 32'h200 + 32'(off) + (32'($urandom_range(0, 3)) << 12);
      logic [31:0] wd = $urandom;
      bit rej = (rd && wr) || (f3 == 3'd3) || (f3 >= 3'd6) || (wr && f3[2]) || (lane % size != 0);
      if (rej) begin
        exp_rd = 32'd0;
        known = rd;
      end else if (rd) begin
        logic [31:0] v = mem_m[off / 4] >> (8 * lane);
        if (size == 1) begin v = v & 32'hFF;   if (!f3[2] && v[7])  v = v | 32'hFFFFFF00; end
        if (size == 2) begin v = v & 32'hFFFF; if (!f3[2] && v[15]) v = v | 32'hFFFF0000; end
        exp_rd = v;
        known = 1;
      end else begin
        logic [63:0] m64 = ((64'd1 << (8 * size)) - 64'd1) << (8 * lane);
        logic [31:0] m = m64[31:0];
        mem_m[off / 4] = (mem_m[off / 4] & ~m) | ((wd << (8 * lane)) & m);
      end
      do_access(0, rd, wr, f3, a, wd, bc, r, e, ea);
      checks++; if (bc !== 3) begin errors++; $display("FAIL rand%0d_busy: got %0d want 3", n, bc); end
      checks++; if (e !== rej) begin errors++; $display("FAIL rand%0d_err: got %b want %b", n, e, rej); end
      checks++; if (ea !== 1'b0) begin errors++; $display("FAIL rand%0d_err_clear: got %b want 0", n, ea); end
      if (known) begin
        checks++;
        if (r !== exp_rd) begin errors++; $display("FAIL rand%0d_rdata: got %08h want %08h", n, r, exp_rd); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    re0 = 0; we0 = 0; f30 = 0; addr0 = 0; wd0 = 0;
    re1 = 0; we1 = 0; f31 = 0; addr1 = 0; wd1 = 0;
    test_reset();
    test_word_round_trip();
    test_extension();
    test_partial_store();
    test_rejections();
    test_wrap_latency();
    test_reset_mid_access();
    test_random_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the data-memory control interface driven by the instruction decoder. It accepts MEM_READ_EN / MEM_WRITE_EN with FUNC3 width/sign encoding in the MEM stage, performs a multi-cycle access to an internal word-organised RAM, and asserts BUSY to stall the pipeline until the access completes. Byte and halfword lane selection, sign/zero extension and misalignment detection are all done here.

## Interface
- ADDR_BITS, 10: word-index width; RAM holds 2^ADDR_BITS 32-bit words.
- ACCESS_LATENCY, 2: cycles spent in ACCESS per request; legal range 1..15.
- CLK  in  1  clock, all state updates on rising edge.
- RESET  in  1  one clock; reset is asynchronous and active-low.
- MEM_READ_EN  in  1  load request from decoder.
- MEM_WRITE_EN  in  1  store request from decoder.
- FUNC3  in  3  access type: 000 B, 001 H, 010 W, 100 BU, 101 HU (stores use 000/001/010 only).
- ADDRESS  in  32  byte address from ALU result.
- WRITE_DATA  in  32  store data (rs2 value).
- READ_DATA  out  32  extended load result, registered.
- BUSY  out  1  pipeline stall request.
- ERROR  out  1  registered; high for the DONE cycle of a rejected request.

## Operation
- FSM states: IDLE, ACCESS, DONE. Request = exactly one of MEM_READ_EN / MEM_WRITE_EN high.
- IDLE: on request or on illegal combination, capture ADDRESS, FUNC3, WRITE_DATA, type; load counter with ACCESS_LATENCY-1; go ACCESS. Otherwise stay.
- ACCESS: decrement counter; at counter 0 go DONE, performing the access on that edge.
- DONE: one cycle; inputs ignored (same instruction still in stage); go IDLE.
- Word index = captured ADDRESS[ADDR_BITS+1:2]; higher address bits ignored (wraps modulo RAM size).
- Loads: select byte lane ADDRESS[1:0] or halfword lane ADDRESS[1]; B/H sign-extend, BU/HU zero-extend, W unmodified.
- Stores: B writes WRITE_DATA[7:0] to selected byte lane; H writes [15:0] to selected halfword; W writes full word; other lanes untouched.
- Rejected request (raises ERROR, no RAM write, READ_DATA <= 0): both enables high; FUNC3 in {011,110,111}; store FUNC3 in {100,101}; H/HU with ADDRESS[0]=1; W with ADDRESS[1:0]!=0. Rejected requests still take full latency.
- READ_DATA holds last load result (or 0 after a rejected load) until the next load completes; stores leave it unchanged.

## Timing
- Request presented in cycle T (state IDLE): BUSY=1 combinationally in T.
- BUSY=1 in cycles T..T+ACCESS_LATENCY; BUSY=0 in DONE, cycle T+ACCESS_LATENCY+1.
- RAM write and READ_DATA/ERROR update on the edge entering DONE; values visible throughout DONE.
- Back-to-back: next request may be presented in cycle after DONE; minimum period ACCESS_LATENCY+2 cycles per access.
- BUSY = (state==ACCESS) or (state==IDLE and any enable high); forced 0 while RESET low.
- Reset (async, RESET low): state IDLE, counter 0, READ_DATA 0, ERROR 0, BUSY 0. RAM contents not reset.
- Reset mid-ACCESS: access aborted, no RAM write, outputs to reset values immediately.
- ERROR clears on the edge leaving DONE.

## Test plan
- Reset: RESET low mid-ACCESS of SW 0xDEADBEEF to 0x40 -> BUSY/READ_DATA/ERROR 0 at once; later LW 0x40 does not return 0xDEADBEEF.
- Word round trip (ACCESS_LATENCY=2): SW 0x12345678 @0x100, then LW @0x100 -> BUSY high exactly 3 cycles each, READ_DATA=0x12345678 in DONE.
- Byte/half extension: word 0x80FF7F01 @0x20; LB @0x23 -> 0xFFFFFF80; LBU @0x23 -> 0x00000080; LH @0x20 -> 0x00007F01; LHU @0x22 -> 0x000080FF; LH @0x22 -> 0xFFFF80FF.
- Partial stores: word 0x00000000 @0x30; SB 0xAA @0x31, SH 0xBBCC @0x32 -> LW @0x30 = 0xBBCCAA00.
- Rejections: LW @0x102, SH @0x105, FUNC3=011 load, both enables -> ERROR=1 in DONE, READ_DATA=0 for loads, RAM @0x100/0x104 unchanged.
- Wrap and latency: ADDR_BITS=10, SW 0x5A5A5A5A @0x1000 -> LW @0x0 returns 0x5A5A5A5A; ACCESS_LATENCY=1 -> BUSY high 2 cycles per access.
